// File: rtl/tap_tempo_pkg.sv
// Shared definitions for the tap-tempo block: FSM encodings, tempo constants, result clamp.
package tap_tempo_pkg;

  localparam int BPM_W = 8;
  localparam int MS_W  = 12;
  localparam logic [15:0] MS_PER_MIN = 16'd60000;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TIMING = 2'd1;
  localparam logic [1:0] S_DIVIDE = 2'd2;

  function automatic logic [BPM_W-1:0] clampBpm(input logic [15:0] q, input int lo, input int hi);
    if (q < 16'(lo))
      return BPM_W'(lo);
    else if (q > 16'(hi))
      return BPM_W'(hi);
    else
      return q[BPM_W-1:0];
  endfunction

endpackage

// File: rtl/tap_tempo_seq_divider.sv
// 16/16 unsigned restoring divider: load on i_start, one quotient bit per cycle, o_done after 16 steps.
module seq_divider (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_dividend,
  input  logic [15:0] i_divisor,
  output logic [15:0] o_quotient,
  output logic        o_done
);

  logic [15:0] r_rem;
  logic [15:0] r_quo;
  logic [15:0] r_den;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [16:0] w_shift;
  logic [16:0] w_diff;

  // The remainder stays below the divisor, so the shifted value always fits in 17 bits.
  assign w_shift    = {r_rem, r_quo[15]};
  assign w_diff     = w_shift - {1'b0, r_den};
  assign o_quotient = r_quo;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        r_rem  <= '0;
        r_quo  <= i_dividend;
        r_den  <= i_divisor;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (!w_diff[16]) begin
          r_rem <= w_diff[15:0];
          r_quo <= {r_quo[14:0], 1'b1};
        end else begin
          r_rem <= w_shift[15:0];
          r_quo <= {r_quo[14:0], 1'b0};
        end
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          r_busy <= 1'b0;
          o_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tap_tempo.sv
// Tap-tempo capture: period between TAP rising edges -> clamped BPM.
// Define TAP_TEMPO_AVG_EN to divide by the mean of the last four intervals.
module tap_tempo
  import tap_tempo_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BPM_MIN     = 30,
  parameter int BPM_MAX     = 250,
  parameter int BPM_DEFAULT = 120,
  parameter int TIMEOUT_MS  = 2000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             TAP,
  output logic [BPM_W-1:0] BPM,
  output logic             VALID,
  output logic             ACTIVE
);

  localparam int PRE_MAX = CLK_HZ / 1000 - 1;
  localparam int PRE_W   = $clog2(CLK_HZ / 1000 + 1);

  logic             r_tapQ;
  logic             w_tapEvt;
  logic [PRE_W-1:0] r_pre;
  logic             w_msTick;
  logic [MS_W-1:0]  r_msCount;
  logic [MS_W-1:0]  w_interval;
  logic [1:0]       r_state;
  logic             r_divStart;
  logic [15:0]      r_divisor;
  logic [15:0]      w_nextDivisor;
  logic [15:0]      w_quotient;
  logic             w_divDone;
  logic             w_snapshot;

  assign w_tapEvt   = TAP & ~r_tapQ;
  assign w_msTick   = (r_pre == PRE_W'(PRE_MAX));
  assign w_interval = (r_msCount == '0) ? MS_W'(1) : r_msCount;
  assign w_snapshot = (r_state == S_TIMING) && w_tapEvt;
  assign ACTIVE     = (r_state != S_IDLE);

  // A tap restarts the millisecond timebase so the next interval is measured from this edge.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_tapQ    <= 1'b0;
      r_pre     <= '0;
      r_msCount <= '0;
    end else begin
      r_tapQ <= TAP;
      if (w_tapEvt) begin
        r_pre     <= '0;
        r_msCount <= '0;
      end else begin
        r_pre <= w_msTick ? '0 : r_pre + PRE_W'(1);
        if (w_msTick && r_msCount != '1)
          r_msCount <= r_msCount + MS_W'(1);
      end
    end
  end

`ifdef TAP_TEMPO_AVG_EN
  logic [MS_W-1:0] r_hist0;
  logic [MS_W-1:0] r_hist1;
  logic [MS_W-1:0] r_hist2;
  logic [1:0]      r_histCnt;
  logic [15:0]     w_sum;

  // The three stored intervals plus the new one form the four-entry average.
  assign w_sum = {4'b0, w_interval} + {4'b0, r_hist0} + {4'b0, r_hist1} + {4'b0, r_hist2};
  assign w_nextDivisor = (r_histCnt == 2'd3) ? (w_sum >> 2) : {4'b0, w_interval};

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_hist0   <= '0;
      r_hist1   <= '0;
      r_hist2   <= '0;
      r_histCnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_hist0   <= '0;
      r_hist1   <= '0;
      r_hist2   <= '0;
      r_histCnt <= '0;
    end else if (w_snapshot) begin
      r_hist2 <= r_hist1;
      r_hist1 <= r_hist0;
      r_hist0 <= w_interval;
      if (r_histCnt != 2'd3)
        r_histCnt <= r_histCnt + 2'd1;
    end
  end
`else
  assign w_nextDivisor = {4'b0, w_interval};
`endif

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_divStart <= 1'b0;
      r_divisor  <= '0;
      BPM        <= BPM_W'(BPM_DEFAULT);
      VALID      <= 1'b0;
    end else begin
      VALID      <= 1'b0;
      r_divStart <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tapEvt)
            r_state <= S_TIMING;
        end
        S_TIMING: begin
          if (w_tapEvt) begin
            r_divisor  <= w_nextDivisor;
            r_divStart <= 1'b1;
            r_state    <= S_DIVIDE;
          end else if (r_msCount == MS_W'(TIMEOUT_MS)) begin
            r_state <= S_IDLE;
          end
        end
        S_DIVIDE: begin
          if (w_divDone) begin
            BPM     <= clampBpm(w_quotient, BPM_MIN, BPM_MAX);
            VALID   <= 1'b1;
            r_state <= S_TIMING;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  seq_divider u_div (
    .i_clk      (CLOCK_50),
    .i_rst      (RESET),
    .i_start    (r_divStart),
    .i_dividend (MS_PER_MIN),
    .i_divisor  (r_divisor),
    .o_quotient (w_quotient),
    .o_done     (w_divDone)
  );

endmodule

// File: tb/tb_tap_tempo.sv
// Directed bench for tap_tempo with CLK_HZ=1000 so one millisecond is one clock cycle.
module tb_tap_tempo;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic       TAP;
  logic [7:0] BPM;
  logic       VALID;
  logic       ACTIVE;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lastTap = 0;

`ifdef TAP_TEMPO_AVG_EN
  localparam logic [7:0] AVG_EXP = 8'd96;
`else
  localparam logic [7:0] AVG_EXP = 8'd60;
`endif

  tap_tempo #(.CLK_HZ(1000)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .TAP      (TAP),
    .BPM      (BPM),
    .VALID    (VALID),
    .ACTIVE   (ACTIVE)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task applyReset;
    RESET = 1'b1;
    TAP = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET = 1'b0;
  endtask

  // TAP goes high for one cycle; the rising edge is sampled on the next posedge.
  task tapEdge;
    @(negedge CLOCK_50);
    TAP = 1'b1;
    @(posedge CLOCK_50);
    #1;
    TAP = 1'b0;
    lastTap = cyc;
  endtask

  task waitUntil(input int target);
    while (cyc < target) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Tap 'gap' cycles after the previous tap (gap 0 = tap now) and watch 25 cycles for VALID.
  task tapWatch(input int gap, output int lat, output int pulses, output logic [7:0] bpmSeen);
    if (gap > 0) waitUntil(lastTap + gap - 1);
    tapEdge;
    lat = -1;
    pulses = 0;
    bpmSeen = 8'd0;
    for (int k = 1; k <= 25; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (VALID) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          bpmSeen = BPM;
        end
      end
    end
  endtask

  task test_reset;
    int pulses;
    RESET = 1'b1;
    TAP = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    total++;
    if (BPM !== 8'd120) begin bad++; $display("[TB] FAIL reset_bpm got=%0d want=120", BPM); end
    total++;
    if (VALID !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", VALID); end
    total++;
    if (ACTIVE !== 1'b0) begin bad++; $display("[TB] FAIL reset_active got=%b want=0", ACTIVE); end
    @(negedge CLOCK_50);
    RESET = 1'b0;
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (VALID) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("[TB] FAIL idle_valid got=%0d pulses want=0", pulses); end
    total++;
    if (ACTIVE !== 1'b0 || BPM !== 8'd120) begin
      bad++; $display("[TB] FAIL idle_state got active=%b bpm=%0d want active=0 bpm=120", ACTIVE, BPM);
    end
  endtask

  task test_intervals;
    int gaps [4] = '{500, 250, 100, 1900};
    logic [7:0] exps [4] = '{8'd120, 8'd240, 8'd250, 8'd31};
    int lat, pulses;
    logic [7:0] seen;
    applyReset;
    tapWatch(0, lat, pulses, seen);
    total++;
    if (ACTIVE !== 1'b1) begin bad++; $display("[TB] FAIL first_tap_active got=%b want=1", ACTIVE); end
    total++;
    if (pulses !== 0) begin bad++; $display("[TB] FAIL first_tap_valid got=%0d pulses want=0", pulses); end
    for (int i = 0; i < 4; i++) begin
      tapWatch(gaps[i], lat, pulses, seen);
      total++;
      if (lat !== 18) begin bad++; $display("[TB] FAIL latency_gap%0d got=%0d want=18", gaps[i], lat); end
      total++;
      if (pulses !== 1) begin bad++; $display("[TB] FAIL pulses_gap%0d got=%0d want=1", gaps[i], pulses); end
      total++;
      if (seen !== exps[i]) begin bad++; $display("[TB] FAIL bpm_gap%0d got=%0d want=%0d", gaps[i], seen, exps[i]); end
      total++;
      if (BPM !== exps[i]) begin bad++; $display("[TB] FAIL bpm_hold_gap%0d got=%0d want=%0d", gaps[i], BPM, exps[i]); end
    end
  endtask

  task test_timeout;
    int lat, pulses;
    logic [7:0] seen;
    logic actEarly, actLate;
    applyReset;
    tapWatch(0, lat, pulses, seen);
    tapWatch(250, lat, pulses, seen);
    total++;
    if (seen !== 8'd240) begin bad++; $display("[TB] FAIL timeout_setup_bpm got=%0d want=240", seen); end
    pulses = 0;
    actEarly = 1'b0;
    actLate = 1'b1;
    while (cyc < lastTap + 2010) begin
      @(posedge CLOCK_50);
      #1;
      if (VALID) pulses++;
      if (cyc == lastTap + 1990) actEarly = ACTIVE;
      if (cyc == lastTap + 2010) actLate = ACTIVE;
    end
    total++;
    if (actEarly !== 1'b1) begin bad++; $display("[TB] FAIL timeout_active_before got=%b want=1", actEarly); end
    total++;
    if (actLate !== 1'b0) begin bad++; $display("[TB] FAIL timeout_active_after got=%b want=0", actLate); end
    total++;
    if (pulses !== 0) begin bad++; $display("[TB] FAIL timeout_valid got=%0d pulses want=0", pulses); end
    total++;
    if (BPM !== 8'd240) begin bad++; $display("[TB] FAIL timeout_bpm got=%0d want=240", BPM); end
  endtask

  task test_reset_mid_divide;
    int lat, pulses;
    logic [7:0] seen;
    applyReset;
    tapWatch(0, lat, pulses, seen);
    waitUntil(lastTap + 249);
    tapEdge;
    repeat (5) @(posedge CLOCK_50);
    #1;
    total++;
    if (ACTIVE !== 1'b1) begin bad++; $display("[TB] FAIL divide_active got=%b want=1", ACTIVE); end
    RESET = 1'b1;
    #1;
    total++;
    if (BPM !== 8'd120 || VALID !== 1'b0 || ACTIVE !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_async got bpm=%0d valid=%b active=%b want bpm=120 valid=0 active=0", BPM, VALID, ACTIVE);
    end
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (VALID) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("[TB] FAIL abort_valid got=%0d pulses want=0", pulses); end
    total++;
    if (BPM !== 8'd120 || ACTIVE !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_state got bpm=%0d active=%b want bpm=120 active=0", BPM, ACTIVE);
    end
  endtask

  task test_average;
    int gaps [4] = '{500, 500, 500, 1000};
    logic [7:0] exps [4];
    int lat, pulses;
    logic [7:0] seen;
    exps = '{8'd120, 8'd120, 8'd120, AVG_EXP};
    applyReset;
    tapWatch(0, lat, pulses, seen);
    for (int i = 0; i < 4; i++) begin
      tapWatch(gaps[i], lat, pulses, seen);
      total++;
      if (seen !== exps[i] || pulses !== 1) begin
        bad++; $display("[TB] FAIL avg_step%0d got bpm=%0d pulses=%0d want bpm=%0d pulses=1", i, seen, pulses, exps[i]);
      end
    end
  endtask

  initial begin
    TAP = 1'b0;
    test_reset;
    test_intervals;
    test_timeout;
    test_reset_mid_divide;
    test_average;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
